// File: rtl/rv_iopmp_pkg.sv
// Shared types for the IOPMP WSI interrupt path: wire mode, pulse FSM states and intb bit positions.
package rv_iopmp_pkg;

    typedef enum logic {
        WSI_LEVEL = 1'b0,
        WSI_PULSE = 1'b1
    } wsi_mode_e;

    typedef enum logic [1:0] {
        WSI_IDLE    = 2'd0,
        WSI_PULSING = 2'd1,
        WSI_ARMED   = 2'd2
    } wsi_fsm_e;

    localparam int unsigned INTB_RD_BIT = 0;
    localparam int unsigned INTB_WR_BIT = 1;

    // An event passes the filter when its one-hot {write, read} type matches an enabled intb bit.
    function automatic logic wsi_evt_accept(input logic [1:0] evt_type, input logic [1:0] intb);
        return (evt_type[INTB_RD_BIT] & intb[INTB_RD_BIT]) |
               (evt_type[INTB_WR_BIT] & intb[INTB_WR_BIT]);
    endfunction

endpackage

// File: rtl/rv_iopmp_wsi_coalescer.sv
// Event-count / timeout coalescing for the WSI interrupt; only instantiated when
// RV_IOPMP_WSI_COALESCE_EN is defined.
module rv_iopmp_wsi_coalescer #(
    parameter int unsigned NR_SRC = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NR_SRC-1:0] accept_i,
    input  logic              any_pend_i,
    input  logic              take_i,
    input  logic [CNT_W-1:0]  thr_i,
    input  logic [CNT_W-1:0]  tmo_i,
    output logic              fire_o
);

    localparam int unsigned SUM_W = CNT_W + 6;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [5:0]       n_accept;
    logic [SUM_W-1:0] evt_sum;
    logic             restart;

    // Events accepted in the same cycle the counters restart still count toward the next fire.
    always_comb begin
        n_accept = '0;
        for (int k = 0; k < NR_SRC; k++) begin
            n_accept = n_accept + 6'(accept_i[k]);
        end
        restart = take_i | ~any_pend_i;
        evt_sum = (restart ? '0 : SUM_W'(evt_cnt_q)) + SUM_W'(n_accept);
        evt_cnt_d = (evt_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : evt_sum[CNT_W-1:0];
        if (restart) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == CNT_MAX) begin
            tmo_cnt_d = CNT_MAX;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            evt_cnt_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign fire_o = any_pend_i & ((evt_cnt_q >= thr_i) | (tmo_cnt_q >= tmo_i));

endmodule

// File: rtl/rv_iopmp_wsi_intr_ctrl.sv
// IOPMP WSI interrupt controller: per-source pending bits with intb filtering, level or pulse wire.
// Optional coalescing is enabled by defining RV_IOPMP_WSI_COALESCE_EN.
module rv_iopmp_wsi_intr_ctrl
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned NR_SRC  = 4,
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wsi_en_i,
    input  logic                mode_i,
    input  logic [1:0]          intb_i,
    input  logic [NR_SRC-1:0]   evt_valid_i,
    input  logic [2*NR_SRC-1:0] evt_type_i,
    input  logic [NR_SRC-1:0]   clr_i,
    input  logic [CNT_W-1:0]    coal_thr_i,
    input  logic [CNT_W-1:0]    coal_tmo_i,
    output logic [NR_SRC-1:0]   pending_o,
    output logic                wsi_wire_o
);

    localparam int unsigned PCNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

    logic [NR_SRC-1:0] accept;
    logic [NR_SRC-1:0] pending_q, pending_d;
    logic              any_pend;
    logic              fire;
    wsi_mode_e         mode;
    wsi_fsm_e          state_q;
    logic              wire_q;
    logic [PCNT_W-1:0] pcnt_q;

    // Set wins over a simultaneous W1C clear.
    always_comb begin
        accept = '0;
        for (int k = 0; k < NR_SRC; k++) begin
            accept[k] = evt_valid_i[k] & wsi_evt_accept(evt_type_i[2*k +: 2], intb_i);
        end
        pending_d = accept | (pending_q & ~clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign any_pend = |pending_q;
    assign mode     = wsi_mode_e'(mode_i);

`ifdef RV_IOPMP_WSI_COALESCE_EN
    logic take;
    assign take = wsi_en_i & (state_q == WSI_IDLE) & fire & ((mode == WSI_PULSE) | ~wire_q);

    rv_iopmp_wsi_coalescer #(
        .NR_SRC (NR_SRC),
        .CNT_W  (CNT_W)
    ) u_coalescer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .accept_i   (accept),
        .any_pend_i (any_pend),
        .take_i     (take),
        .thr_i      (coal_thr_i),
        .tmo_i      (coal_tmo_i),
        .fire_o     (fire)
    );
`else
    logic [2*CNT_W-1:0] unused_coal;
    assign unused_coal = {coal_thr_i, coal_tmo_i};
    assign fire        = any_pend;
`endif

    // Level mode keeps the wire up until pending drains, even once coalescing counters restart.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || !wsi_en_i) begin
            state_q <= WSI_IDLE;
            wire_q  <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            case (state_q)
                WSI_IDLE: begin
                    if (mode == WSI_PULSE) begin
                        if (fire) begin
                            state_q <= WSI_PULSING;
                            wire_q  <= 1'b1;
                            pcnt_q  <= PCNT_W'(PULSE_W - 1);
                        end else begin
                            wire_q <= 1'b0;
                        end
                    end else begin
                        wire_q <= fire | (wire_q & any_pend);
                    end
                end
                WSI_PULSING: begin
                    if (pcnt_q == '0) begin
                        state_q <= WSI_ARMED;
                        wire_q  <= 1'b0;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                WSI_ARMED: begin
                    wire_q <= 1'b0;
                    if (!any_pend) begin
                        state_q <= WSI_IDLE;
                    end
                end
                default: begin
                    state_q <= WSI_IDLE;
                    wire_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pending_o  = pending_q;
    assign wsi_wire_o = wire_q;

endmodule

// File: tb/tb_rv_iopmp_wsi_intr_ctrl.sv
// Self-checking bench for rv_iopmp_wsi_intr_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a cycle-count reference model (coalescing scenario under RV_IOPMP_WSI_COALESCE_EN).
module tb_rv_iopmp_wsi_intr_ctrl;

    localparam int NR_SRC  = 4;
    localparam int PULSE_W = 4;
    localparam int CNT_W   = 8;

    logic                clk = 1'b0;
    logic                rstN = 1'b0;
    logic                wsiEn = 1'b1;
    logic                mode = 1'b0;
    logic [1:0]          intb = 2'b01;
    logic [NR_SRC-1:0]   evtValid = '0;
    logic [2*NR_SRC-1:0] evtType = '0;
    logic [NR_SRC-1:0]   clr = '0;
    logic [CNT_W-1:0]    coalThr = '0;
    logic [CNT_W-1:0]    coalTmo = '0;
    logic [NR_SRC-1:0]   pending;
    logic                wsiWire;

    int checks = 0;
    int failures = 0;
    bit modelOn = 1'b1;

    // Reference model: pending set, wire value, cycles of pulse remaining, armed flag.
    logic [NR_SRC-1:0] mPend = '0;
    logic              mWire = 1'b0;
    int                mLeft = 0;
    bit                mArmed = 1'b0;

    rv_iopmp_wsi_intr_ctrl #(
        .NR_SRC  (NR_SRC),
        .PULSE_W (PULSE_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .wsi_en_i    (wsiEn),
        .mode_i      (mode),
        .intb_i      (intb),
        .evt_valid_i (evtValid),
        .evt_type_i  (evtType),
        .clr_i       (clr),
        .coal_thr_i  (coalThr),
        .coal_tmo_i  (coalTmo),
        .pending_o   (pending),
        .wsi_wire_o  (wsiWire)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelUpdate();
        logic [NR_SRC-1:0] acc;
        bit anyP;
        anyP = |mPend;
        for (int k = 0; k < NR_SRC; k++) begin
            acc[k] = evtValid[k] & (|(evtType[2*k +: 2] & intb));
        end
        if (!rstN) begin
            mPend = '0;
            mWire = 1'b0;
            mLeft = 0;
            mArmed = 1'b0;
        end else begin
            if (!wsiEn) begin
                mLeft = 0;
                mArmed = 1'b0;
                mWire = 1'b0;
            end else if (mLeft > 0) begin
                mLeft--;
                mWire = (mLeft > 0);
                mArmed = (mLeft == 0);
            end else if (mArmed) begin
                mWire = 1'b0;
                if (!anyP) mArmed = 1'b0;
            end else if (mode) begin
                if (anyP) begin
                    mLeft = PULSE_W;
                    mWire = 1'b1;
                end else begin
                    mWire = 1'b0;
                end
            end else begin
                mWire = anyP;
            end
            mPend = acc | (mPend & ~clr);
        end
    endtask

    // One clock: inputs sampled at the edge, model advanced, outputs compared 1ns later, strobes dropped.
    task automatic applyStimulus();
        @(posedge clk);
        modelUpdate();
        #1;
        evtValid = '0;
        clr = '0;
        if (modelOn) begin
            checkOutput("model_pending", 32'(pending), 32'(mPend));
            checkOutput("model_wire", 32'(wsiWire), 32'(mWire));
        end
    endtask

    task automatic countHighs(input int cycles, output int highs);
        highs = 0;
        for (int c = 0; c < cycles; c++) begin
            applyStimulus();
            highs += int'(wsiWire);
        end
    endtask

    initial begin
        int highs;
        evtType = 8'h55;

        $display("[TB] reset with all events asserted");
        rstN = 1'b0;
        for (int c = 0; c < 3; c++) begin
            evtValid = 4'hF;
            applyStimulus();
            checkOutput("reset_pending", 32'(pending), 32'h0);
            checkOutput("reset_wire", 32'(wsiWire), 32'h0);
        end
        rstN = 1'b1;
        applyStimulus();

        $display("[TB] level mode with read filter");
        mode = 1'b0;
        intb = 2'b01;
        evtType = 8'h10;
        evtValid = 4'b0100;
        applyStimulus();
        checkOutput("level_pending", 32'(pending), 32'h4);
        checkOutput("level_wire_lag", 32'(wsiWire), 32'h0);
        applyStimulus();
        checkOutput("level_wire_up", 32'(wsiWire), 32'h1);
        evtType = 8'h20;
        evtValid = 4'b0100;
        applyStimulus();
        checkOutput("filtered_write", 32'(pending), 32'h4);
        clr = 4'b0100;
        applyStimulus();
        checkOutput("clr_pending", 32'(pending), 32'h0);
        checkOutput("clr_wire_lag", 32'(wsiWire), 32'h1);
        applyStimulus();
        checkOutput("clr_wire_down", 32'(wsiWire), 32'h0);

        $display("[TB] pulse mode");
        mode = 1'b1;
        evtType = 8'h55;
        evtValid = 4'b0001;
        applyStimulus();
        countHighs(10, highs);
        checkOutput("pulse_width", 32'(highs), 32'(PULSE_W));
        evtValid = 4'b0010;
        applyStimulus();
        countHighs(8, highs);
        checkOutput("armed_no_retrigger", 32'(highs), 32'h0);
        clr = 4'hF;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        evtValid = 4'b0001;
        applyStimulus();
        countHighs(10, highs);
        checkOutput("pulse_rearm_width", 32'(highs), 32'(PULSE_W));
        clr = 4'hF;
        applyStimulus();
        applyStimulus();

        $display("[TB] set/clear collision");
        mode = 1'b0;
        evtValid = 4'b0010;
        clr = 4'b0010;
        applyStimulus();
        checkOutput("collision_set_wins", 32'(pending[1]), 32'h1);
        clr = 4'hF;
        applyStimulus();
        applyStimulus();

        $display("[TB] global enable");
        wsiEn = 1'b0;
        evtValid = 4'b1000;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("disabled_pending", 32'(pending[3]), 32'h1);
        checkOutput("disabled_wire", 32'(wsiWire), 32'h0);
        wsiEn = 1'b1;
        applyStimulus();
        checkOutput("enable_wire_up", 32'(wsiWire), 32'h1);
        clr = 4'hF;
        applyStimulus();
        applyStimulus();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) intb = 2'($urandom);
            if (i % 60 == 0) mode = 1'($urandom);
            wsiEn = ($urandom_range(0, 9) != 0);
            rstN = ($urandom_range(0, 99) != 0);
            for (int k = 0; k < NR_SRC; k++) begin
                evtValid[k] = ($urandom_range(0, 3) == 0);
                clr[k] = ($urandom_range(0, 5) == 0);
            end
            evtType = 8'($urandom);
            applyStimulus();
        end
        rstN = 1'b1;
        wsiEn = 1'b1;

`ifdef RV_IOPMP_WSI_COALESCE_EN
        $display("[TB] coalescing threshold and timeout");
        modelOn = 1'b0;
        mode = 1'b0;
        intb = 2'b01;
        evtType = 8'h55;
        coalThr = 8'd3;
        coalTmo = 8'd20;
        clr = 4'hF;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("coal_idle_wire", 32'(wsiWire), 32'h0);
        for (int c = 0; c <= 9; c++) begin
            evtValid = (c == 0 || c == 5 || c == 9) ? 4'b0001 : 4'b0000;
            applyStimulus();
        end
        checkOutput("coal_thr_before", 32'(wsiWire), 32'h0);
        applyStimulus();
        checkOutput("coal_thr_fire", 32'(wsiWire), 32'h1);
        clr = 4'hF;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("coal_drain_wire", 32'(wsiWire), 32'h0);
        evtValid = 4'b0001;
        applyStimulus();
        for (int c = 0; c < 20; c++) applyStimulus();
        checkOutput("coal_tmo_before", 32'(wsiWire), 32'h0);
        applyStimulus();
        checkOutput("coal_tmo_fire", 32'(wsiWire), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
